// File: rtl/decomp_pkg.sv
// Shared page-record definitions for the generator, page buffer and distributor.
// The pack/unpack pair fixes the bit layout of a stored page record.
package decomp_pkg;

    localparam int PAGE_DATA_W = 144;
    localparam int PAGE_POS_W  = 16;
    localparam int PAGE_ADDR_W = 17;
    localparam int PAGE_GARB_W = 2;
    localparam int PAGE_REC_W  = PAGE_DATA_W + PAGE_POS_W + PAGE_ADDR_W + PAGE_GARB_W + 1;

    typedef struct packed {
        logic [PAGE_DATA_W-1:0] data;
        logic [PAGE_POS_W-1:0]  position;
        logic [PAGE_ADDR_W-1:0] address;
        logic [PAGE_GARB_W-1:0] garbage;
        logic                   lit_flag;
    } page_rec_t;

    // Layout, MSB first: data, position, address, garbage, lit_flag.
    function automatic logic [PAGE_REC_W-1:0] pack_page(input page_rec_t rec);
        return {rec.data, rec.position, rec.address, rec.garbage, rec.lit_flag};
    endfunction

    function automatic page_rec_t unpack_page(input logic [PAGE_REC_W-1:0] bits);
        page_rec_t rec;
        {rec.data, rec.position, rec.address, rec.garbage, rec.lit_flag} = bits;
        return rec;
    endfunction

endpackage

// File: rtl/page_fifo_if.sv
// Generator/distributor-facing signals of the show-ahead page buffer.
// Handshake: a write is taken when wr_en=1 and full=0; a pop is taken when rdreq=1 and valid_out=1.
interface page_fifo_if #(
    parameter int DEPTH_LOG2 = 6
);
    import decomp_pkg::*;

    logic                   flush;
    logic                   wr_en;
    logic [PAGE_DATA_W-1:0] data_in;
    logic [PAGE_POS_W-1:0]  position_in;
    logic [PAGE_ADDR_W-1:0] address_in;
    logic [PAGE_GARB_W-1:0] garbage_in;
    logic                   lit_flag_in;
    logic                   full;
    logic                   almost_full;
    logic                   overflow;
    logic [PAGE_DATA_W-1:0] data_out;
    logic [PAGE_POS_W-1:0]  position_out;
    logic [PAGE_ADDR_W-1:0] address_out;
    logic [PAGE_GARB_W-1:0] garbage_out;
    logic                   lit_flag_out;
    logic                   valid_out;
    logic                   rdreq;
    logic [DEPTH_LOG2:0]    count;

    modport master (
        output flush, wr_en, data_in, position_in, address_in, garbage_in, lit_flag_in, rdreq,
        input  full, almost_full, overflow, data_out, position_out, address_out,
               garbage_out, lit_flag_out, valid_out, count
    );

    modport slave (
        input  flush, wr_en, data_in, position_in, address_in, garbage_in, lit_flag_in, rdreq,
        output full, almost_full, overflow, data_out, position_out, address_out,
               garbage_out, lit_flag_out, valid_out, count
    );

endinterface

// File: rtl/page_fifo_ram.sv
// Record storage: one synchronous write port, one asynchronous read port, no reset on the array.
module page_fifo_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 180
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/page_fifo.sv
// Show-ahead page buffer: the head record is presented combinationally from the storage array,
// flags decode only from registered pointers/count so nothing combinational reaches rdreq/wr_en.
module page_fifo
    import decomp_pkg::*;
#(
    parameter int DEPTH_LOG2   = 6,
    parameter int AFULL_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    page_fifo_if.slave  fifo_if
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [PW-1:0] ONE       = PW'(1);
    localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_MARGIN);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          empty, full;
    logic          wr_acc, rd_acc;
    page_rec_t     wr_rec, rd_rec;
    logic [PAGE_REC_W-1:0] rd_bits;

    // Pointers carry a wrap bit above the index so full and empty are distinguishable.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                    (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign wr_acc = fifo_if.wr_en & ~full & ~fifo_if.flush;
    assign rd_acc = fifo_if.rdreq & ~empty & ~fifo_if.flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (fifo_if.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
            if (wr_acc && !rd_acc) count_d = count_q + ONE;
            if (rd_acc && !wr_acc) count_d = count_q - ONE;
            if (fifo_if.wr_en && full) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        wr_rec          = '0;
        wr_rec.data     = fifo_if.data_in;
        wr_rec.position = fifo_if.position_in;
        wr_rec.address  = fifo_if.address_in;
        wr_rec.garbage  = fifo_if.garbage_in;
        wr_rec.lit_flag = fifo_if.lit_flag_in;
    end

    page_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (PAGE_REC_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata (pack_page(wr_rec)),
        .raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata (rd_bits)
    );

    assign rd_rec = unpack_page(rd_bits);

    assign fifo_if.data_out     = rd_rec.data;
    assign fifo_if.position_out = rd_rec.position;
    assign fifo_if.address_out  = rd_rec.address;
    assign fifo_if.garbage_out  = rd_rec.garbage;
    assign fifo_if.lit_flag_out = rd_rec.lit_flag;
    assign fifo_if.valid_out    = ~empty;
    assign fifo_if.full         = full;
    assign fifo_if.almost_full  = (count_q >= AFULL_LVL);
    assign fifo_if.overflow     = overflow_q;
    assign fifo_if.count        = count_q;

endmodule

// File: tb/tb_page_fifo.sv
// Bench for page_fifo: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the page buffer.
module tb_page_fifo;

    localparam int DEPTH = 64;
    localparam int AFULL = 60;
    localparam int RW    = 180;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    page_fifo_if #(.DEPTH_LOG2(6)) fif ();

    page_fifo #(.DEPTH_LOG2(6), .AFULL_MARGIN(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (fif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: queue of stored records plus the sticky overflow flag.
    logic [RW-1:0] exp_q[$];
    logic          exp_ovf = 1'b0;

    typedef struct {
        logic        f;
        logic        w;
        logic        r;
        logic [16:0] addr;
        int          exp_count;
        logic        exp_valid;
        logic [16:0] exp_head;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] make_rec(input logic [16:0] addr);
        logic [143:0] d;
        logic [15:0]  p;
        d = {addr[7:0], {8{addr}}};
        p = addr[15:0] ^ 16'hA5A5;
        return {d, p, addr, addr[1:0], addr[2]};
    endfunction

    function automatic logic [RW-1:0] rand_rec();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[RW-1:0];
    endfunction

    function automatic logic [RW-1:0] dut_head();
        return {fif.data_out, fif.position_out, fif.address_out, fif.garbage_out, fif.lit_flag_out};
    endfunction

    task automatic drive(input logic f, input logic w, input logic r, input logic [RW-1:0] rec);
        fif.flush       = f;
        fif.wr_en       = w;
        fif.rdreq       = r;
        fif.data_in     = rec[179:36];
        fif.position_in = rec[35:20];
        fif.address_in  = rec[19:3];
        fif.garbage_in  = rec[2:1];
        fif.lit_flag_in = rec[0];
    endtask

    task automatic model_edge(input logic f, input logic w, input logic r, input logic [RW-1:0] rec);
        int n;
        n = exp_q.size();
        if (f) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (w && n == DEPTH) exp_ovf = 1'b1;
            if (r && n > 0) void'(exp_q.pop_front());
            if (w && n < DEPTH) exp_q.push_back(rec);
        end
    endtask

    task automatic check_model();
        int n;
        n = exp_q.size();
        chk("valid_out", RW'(fif.valid_out), RW'(n != 0));
        chk("count", RW'(fif.count), RW'(n));
        chk("full", RW'(fif.full), RW'(n == DEPTH));
        chk("almost_full", RW'(fif.almost_full), RW'(n >= AFULL));
        chk("overflow", RW'(fif.overflow), RW'(exp_ovf));
        if (n != 0) chk("head", dut_head(), exp_q[0]);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
    task automatic cycle(input logic f, input logic w, input logic r, input logic [RW-1:0] rec);
        drive(f, w, r, rec);
        @(posedge clk);
        model_edge(f, w, r, rec);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 17'h0,    0, 1'b0, 17'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 17'h0,    0, 1'b0, 17'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 17'h1,    1, 1'b1, 17'h1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 17'h2,    2, 1'b1, 17'h1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 17'h3,    3, 1'b1, 17'h1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 17'h0,    2, 1'b1, 17'h2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 17'h0,    1, 1'b1, 17'h3};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 17'h0,    0, 1'b0, 17'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 17'h4,    1, 1'b1, 17'h4};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 17'h5,    1, 1'b1, 17'h5};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 17'h6,    0, 1'b0, 17'h0};

        drive(1'b0, 1'b0, 1'b0, '0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        check_model();
        // Idle reads on an empty buffer.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, '0);

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].f, vecs[i].w, vecs[i].r, make_rec(vecs[i].addr));
            chk("vec_count", RW'(fif.count), RW'(vecs[i].exp_count));
            chk("vec_valid", RW'(fif.valid_out), RW'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk("vec_head", dut_head(), make_rec(vecs[i].exp_head));
        end

        // Offset the pointers, then fill past capacity so the storage index wraps.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, rand_rec());
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, make_rec(17'(i + 16)));
            if (i == AFULL - 2) chk("afull_below", RW'(fif.almost_full), RW'(0));
            if (i == AFULL - 1) chk("afull_at60", RW'(fif.almost_full), RW'(1));
            if (i == DEPTH - 2) chk("full_below", RW'(fif.full), RW'(0));
        end
        chk("full_at64", RW'(fif.full), RW'(1));
        cycle(1'b0, 1'b1, 1'b0, make_rec(17'h1FFFF));
        chk("ovf_after_65th", RW'(fif.overflow), RW'(1));
        chk("count_after_65th", RW'(fif.count), RW'(64));
        // Pop while full with a write attempt: pop taken, write dropped.
        cycle(1'b0, 1'b1, 1'b1, make_rec(17'h1FFFE));
        chk("full_wr_rd_count", RW'(fif.count), RW'(63));
        for (int i = 0; i < 63; i++) begin
            chk("drain_order", RW'(fif.address_out), RW'(i + 17));
            cycle(1'b0, 1'b0, 1'b1, '0);
        end
        chk("drained_valid", RW'(fif.valid_out), RW'(0));

        // Steady-state streaming at count 10.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, make_rec(17'(100 + i)));
        for (int i = 0; i < 20; i++) begin
            chk("stream_head", RW'(fif.address_out), RW'(100 + i));
            cycle(1'b0, 1'b1, 1'b1, make_rec(17'(110 + i)));
        end
        chk("stream_count", RW'(fif.count), RW'(10));

        // Flush at count 30 with overflow set, overriding a concurrent write and read.
        for (int i = 0; i < 54; i++) cycle(1'b0, 1'b1, 1'b0, rand_rec());
        cycle(1'b0, 1'b1, 1'b0, rand_rec());
        for (int i = 0; i < 34; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        chk("pre_flush_count", RW'(fif.count), RW'(30));
        chk("pre_flush_ovf", RW'(fif.overflow), RW'(1));
        cycle(1'b1, 1'b1, 1'b1, rand_rec());
        chk("flush_count", RW'(fif.count), RW'(0));
        chk("flush_valid", RW'(fif.valid_out), RW'(0));
        chk("flush_ovf", RW'(fif.overflow), RW'(0));

        // Asynchronous reset between edges at count 20.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, rand_rec());
        drive(1'b0, 1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", RW'(fif.valid_out), RW'(0));
        chk("async_rst_count", RW'(fif.count), RW'(0));
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, make_rec(17'h0ABCD));
        chk("post_rst_count", RW'(fif.count), RW'(1));
        chk("post_rst_head", dut_head(), make_rec(17'h0ABCD));
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, '0);

        // Random traffic with biased write/read rates to visit empty and full.
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 500; i++) begin
                logic f, w, r;
                f = ($urandom_range(0, 199) == 0);
                w = ($urandom_range(0, 99) < ((phase % 2 == 0) ? 75 : 35));
                r = ($urandom_range(0, 99) < ((phase % 2 == 0) ? 35 : 75));
                cycle(f, w, r, rand_rec());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
